// File: rtl/display_arbiter.sv
// Two-requester front end for the 4-digit seven-segment display: port A preempts
// port B for HOLD_CYCLES cycles after its last write, B is shadowed and reappears afterwards.
module display_arbiter #(
  parameter logic [15:0] HOLD_CYCLES = 16'd50000,
  parameter int          HOLD_W      = 16,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [15:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [15:0] b_data,
  output logic        b_ready,
  output logic        a_active,
  output logic [6:0]  digit_3,
  output logic [6:0]  digit_2,
  output logic [6:0]  digit_1,
  output logic [6:0]  digit_0
);

  typedef enum logic {SHOW_B = 1'b0, SHOW_A = 1'b1} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 16'd1);
  localparam logic [6:0] BLANK_RESET = BLANK_LZ ? 7'h00 : 7'h3F;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  timer_q, timer_d;
  logic [15:0]        a_reg, a_reg_d, b_reg, b_reg_d;
  logic [15:0]        shown;
  logic               a_acc, b_acc;
  logic               blank_3, blank_2, blank_1;

  assign a_ready = 1'b1;
  assign b_ready = 1'b1;
  assign a_acc   = a_valid && a_ready;
  assign b_acc   = b_valid && b_ready;

  function automatic logic [6:0] seg(input logic [3:0] nib);
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
  endfunction

  // A write always wins and restarts the hold; otherwise the hold counts down and
  // releases the display back to B on the cycle after it reaches zero.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    a_reg_d = a_reg;
    b_reg_d = b_reg;
    if (b_acc) b_reg_d = b_data;
    if (a_acc) begin
      a_reg_d = a_data;
      timer_d = HOLD_LOAD;
      state_d = SHOW_A;
    end else if (state_q == SHOW_A) begin
      if (timer_q == '0) state_d = SHOW_B;
      else               timer_d = timer_q - 1'b1;
    end
  end

  // Outputs are computed from next-state data so they land one edge after the accept.
  always_comb begin
    shown   = (state_d == SHOW_A) ? a_reg_d : b_reg_d;
    blank_3 = BLANK_LZ && (shown[15:12] == 4'h0);
    blank_2 = blank_3 && (shown[11:8] == 4'h0);
    blank_1 = blank_2 && (shown[7:4] == 4'h0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SHOW_B;
      timer_q  <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      a_active <= 1'b0;
      digit_3  <= BLANK_RESET;
      digit_2  <= BLANK_RESET;
      digit_1  <= BLANK_RESET;
      digit_0  <= 7'h3F;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      a_reg    <= a_reg_d;
      b_reg    <= b_reg_d;
      a_active <= (state_d == SHOW_A);
      digit_3  <= blank_3 ? 7'h00 : seg(shown[15:12]);
      digit_2  <= blank_2 ? 7'h00 : seg(shown[11:8]);
      digit_1  <= blank_1 ? 7'h00 : seg(shown[7:4]);
      digit_0  <= seg(shown[3:0]);
    end
  end

endmodule
